// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo front end: opcode encodings, instruction
// field positions and the opcode-to-station classification.
package tomasulo_pkg;

    localparam int INSTR_W = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 7;
    localparam int OFF_MSB = 6;
    localparam int OFF_LSB = 0;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LD   = 3'b011;
    localparam logic [2:0] OP_ST   = 3'b100;
    localparam logic [2:0] OP_RSV5 = 3'b101;
    localparam logic [2:0] OP_RSV6 = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        TGT_AS,
        TGT_LS,
        TGT_DROP,
        TGT_ILLEGAL
    } target_e;

    typedef enum logic {
        ST_READY,
        ST_COOL
    } issue_state_e;

    function automatic target_e op_target(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI: op_target = TGT_AS;
            OP_LD, OP_ST:            op_target = TGT_LS;
            OP_NOP:                  op_target = TGT_DROP;
            OP_RSV5, OP_RSV6:        op_target = TGT_ILLEGAL;
            default:                 op_target = TGT_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/instr_issue_unit_fifo.sv
// Synchronous instruction FIFO with occupancy count, synchronous clear and a
// combinational view of the head entry.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_issue_unit.sv
// In-order issue stage: buffers fetched instructions and issues the head to the
// add/sub or load/store reservation station, stalling in program order.
module instr_issue_unit
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic                   in_valid,
    input  logic [15:0]            in_instr,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   asrs_full,
    input  logic                   lsrs_full,
    output logic [2:0]             opcode,
    output logic [2:0]             rd,
    output logic [2:0]             rs,
    output logic [6:0]             offset,
    output logic                   issue_as,
    output logic                   issue_ls,
    output logic                   illegal,
    output logic [$clog2(DEPTH):0] count
);

    logic [INSTR_W-1:0] head_p0;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    target_e            tgt_p0;
    logic               deq_as;
    logic               deq_ls;
    logic               deq_ill;
    issue_state_e       as_state, as_next;
    issue_state_e       ls_state, ls_next;

    logic               issue_as_p1;
    logic               issue_ls_p1;
    logic               illegal_p1;
    logic [2:0]         opcode_p1;
    logic [2:0]         rd_p1;
    logic [2:0]         rs_p1;
    logic [6:0]         offset_p1;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & ~fifo_full & ~flush;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .CLK   (CLK),
        .CLR   (CLR),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (in_instr),
        .head  (head_p0),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stage p0: classify the head and decide whether it can leave this cycle.
    assign tgt_p0 = op_target(head_p0[OP_MSB:OP_LSB]);

    always_comb begin
        deq_as  = 1'b0;
        deq_ls  = 1'b0;
        deq_ill = 1'b0;
        pop     = 1'b0;
        if (!fifo_empty && !flush) begin
            case (tgt_p0)
                TGT_AS: begin
                    deq_as = ~asrs_full & (as_state == ST_READY);
                    pop    = deq_as;
                end
                TGT_LS: begin
                    deq_ls = ~lsrs_full & (ls_state == ST_READY);
                    pop    = deq_ls;
                end
                TGT_DROP: pop = 1'b1;
                default: begin
                    deq_ill = 1'b1;
                    pop     = 1'b1;
                end
            endcase
        end
    end

    // Cooldown gives each station one cycle to update its full flag after a capture.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            as_state <= ST_READY;
            ls_state <= ST_READY;
        end else begin
            as_state <= as_next;
            ls_state <= ls_next;
        end
    end

    always_comb begin
        as_next = as_state;
        ls_next = ls_state;
        if (flush) begin
            as_next = ST_READY;
            ls_next = ST_READY;
        end else begin
            case (as_state)
                ST_READY: if (deq_as) as_next = ST_COOL;
                ST_COOL:  as_next = ST_READY;
                default:  as_next = ST_READY;
            endcase
            case (ls_state)
                ST_READY: if (deq_ls) ls_next = ST_COOL;
                ST_COOL:  ls_next = ST_READY;
                default:  ls_next = ST_READY;
            endcase
        end
    end

    // Stage p1: registered strobes and issued fields; fields hold between issues.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            issue_as_p1 <= 1'b0;
            issue_ls_p1 <= 1'b0;
            illegal_p1  <= 1'b0;
            opcode_p1   <= '0;
            rd_p1       <= '0;
            rs_p1       <= '0;
            offset_p1   <= '0;
        end else begin
            issue_as_p1 <= deq_as;
            issue_ls_p1 <= deq_ls;
            illegal_p1  <= deq_ill;
            if (deq_as || deq_ls) begin
                opcode_p1 <= head_p0[OP_MSB:OP_LSB];
                rd_p1     <= head_p0[RD_MSB:RD_LSB];
                rs_p1     <= head_p0[RS_MSB:RS_LSB];
                offset_p1 <= head_p0[OFF_MSB:OFF_LSB];
            end
        end
    end

    assign issue_as = issue_as_p1;
    assign issue_ls = issue_ls_p1;
    assign illegal  = illegal_p1;
    assign opcode   = opcode_p1;
    assign rd       = rd_p1;
    assign rs       = rs_p1;
    assign offset   = offset_p1;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_instr_issue_unit;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        flush;
    logic        asrs_full;
    logic        lsrs_full;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [6:0]  offset;
    logic        issue_as;
    logic        issue_ls;
    logic        illegal;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    instr_issue_unit #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .asrs_full (asrs_full),
        .lsrs_full (lsrs_full),
        .opcode    (opcode),
        .rd        (rd),
        .rs        (rs),
        .offset    (offset),
        .issue_as  (issue_as),
        .issue_ls  (issue_ls),
        .illegal   (illegal),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] r_d;
        logic [2:0] r_s;
        logic [6:0] off;
        logic       e_as;
        logic       e_ls;
        logic       e_ill;
        logic [2:0] e_op;
        logic [2:0] e_rd;
        logic [2:0] e_rs;
        logic [6:0] e_off;
    } vec_t;

    vec_t vt [8];

    // strobe monitor state for directed windows
    int          cyc;
    int          nstrobe;
    int          n_ill;
    int          first_cyc;
    int          last_cyc;
    logic [31:0] seq;
    logic [31:0] offs;
    int          both_high;

    // reference model state
    logic [15:0] mq [$];
    int          last_as;
    int          last_ls;
    int          edge_n;
    logic        m_as, m_ls, m_ill;
    logic [2:0]  m_op, m_rd, m_rs;
    logic [6:0]  m_off;
    logic [15:0] h;
    int          sz;
    logic [31:0] exp_v;
    logic [31:0] act_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] d,
                                       input logic [2:0] s, input logic [6:0] o);
        return {op, d, s, o};
    endfunction

    task automatic mon_clear();
        nstrobe   = 0;
        n_ill     = 0;
        first_cyc = -1;
        last_cyc  = -1;
        seq       = 0;
        offs      = 0;
        both_high = 0;
    endtask

    task automatic mon_sample();
        if ((issue_as + issue_ls + illegal) > 1) both_high++;
        if (illegal) n_ill++;
        if (issue_as || issue_ls) begin
            nstrobe++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            seq  = (seq << 4) | (issue_as ? 32'h1 : 32'h2);
            offs = (offs << 8) | {25'd0, offset};
        end
    endtask

    task automatic push_one(input logic [15:0] w);
        in_instr = w;
        in_valid = 1'b1;
        tick();
        mon_sample();
        in_valid = 1'b0;
    endtask

    function automatic int cls(input logic [2:0] op);
        if (op <= 3'd2) return 0;
        if (op == 3'd3 || op == 3'd4) return 1;
        if (op == 3'd7) return 2;
        return 3;
    endfunction

    initial begin
        CLR       = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        asrs_full = 1'b0;
        lsrs_full = 1'b0;
        cyc       = 0;

        vt[0] = '{3'd0, 3'd1, 3'd2, 7'h05, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 7'h05};
        vt[1] = '{3'd3, 3'd3, 3'd4, 7'h40, 1'b0, 1'b1, 1'b0, 3'd3, 3'd3, 3'd4, 7'h40};
        vt[2] = '{3'd7, 3'd5, 3'd6, 7'h11, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 3'd4, 7'h40};
        vt[3] = '{3'd5, 3'd7, 3'd7, 7'h7f, 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 3'd4, 7'h40};
        vt[4] = '{3'd4, 3'd2, 3'd5, 7'h2a, 1'b0, 1'b1, 1'b0, 3'd4, 3'd2, 3'd5, 7'h2a};
        vt[5] = '{3'd2, 3'd6, 3'd1, 7'h7f, 1'b1, 1'b0, 1'b0, 3'd2, 3'd6, 3'd1, 7'h7f};
        vt[6] = '{3'd1, 3'd7, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0, 3'd1, 3'd7, 3'd0, 7'h00};
        vt[7] = '{3'd6, 3'd0, 3'd3, 7'h01, 1'b0, 1'b0, 1'b1, 3'd1, 3'd7, 3'd0, 7'h00};

        // reset state
        repeat (2) tick();
        chk("reset_count", 32'(count), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_strobes", {29'd0, issue_as, issue_ls, illegal}, 0);
        chk("reset_fields", {16'd0, opcode, rd, rs, offset}, 0);
        CLR = 1'b1;
        tick();

        // single-instruction vector table
        for (int i = 0; i < 8; i++) begin
            in_instr = mk(vt[i].op, vt[i].r_d, vt[i].r_s, vt[i].off);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_count_after_push", i), 32'(count), 1);
            tick();
            chk($sformatf("vec%0d_strobes", i), {29'd0, issue_as, issue_ls, illegal},
                {29'd0, vt[i].e_as, vt[i].e_ls, vt[i].e_ill});
            chk($sformatf("vec%0d_fields", i), {16'd0, opcode, rd, rs, offset},
                {16'd0, vt[i].e_op, vt[i].e_rd, vt[i].e_rs, vt[i].e_off});
            chk($sformatf("vec%0d_count_after_deq", i), 32'(count), 0);
            tick();
            chk($sformatf("vec%0d_strobe_one_cycle", i), {29'd0, issue_as, issue_ls, illegal}, 0);
        end

        // back-to-back ADD, SUB, LD, ST
        mon_clear();
        push_one(mk(3'd0, 3'd1, 3'd1, 7'h01));
        push_one(mk(3'd1, 3'd2, 3'd2, 7'h02));
        push_one(mk(3'd3, 3'd3, 3'd3, 7'h03));
        push_one(mk(3'd4, 3'd4, 3'd4, 7'h04));
        repeat (10) begin tick(); mon_sample(); end
        chk("b2b_nstrobe", 32'(nstrobe), 4);
        chk("b2b_station_order", seq, 32'h1122);
        chk("b2b_program_order", offs, 32'h01020304);
        chk("b2b_span_cycles", 32'(last_cyc - first_cyc + 1), 6);
        chk("b2b_exclusive", 32'(both_high), 0);

        // stall: ADD blocked, LD behind must not bypass
        mon_clear();
        asrs_full = 1'b1;
        push_one(mk(3'd0, 3'd1, 3'd2, 7'h09));
        push_one(mk(3'd3, 3'd1, 3'd2, 7'h0a));
        repeat (4) begin tick(); mon_sample(); end
        chk("stall_no_strobe", 32'(nstrobe), 0);
        chk("stall_count", 32'(count), 2);
        asrs_full = 1'b0;
        repeat (6) begin tick(); mon_sample(); end
        chk("stall_release_order", offs, 32'h090a);
        chk("stall_release_stations", seq, 32'h12);

        // fill past DEPTH while stalled, then drain across pointer wrap
        mon_clear();
        asrs_full = 1'b1;
        exp_v = 0;
        for (int k = 0; k <= DEPTH; k++) begin
            in_instr = mk(3'd0, 3'd2, 3'd3, 7'(32'h20 + k));
            in_valid = 1'b1;
            if (k == DEPTH) begin
                chk("full_in_ready", 32'(in_ready), 0);
                chk("full_count", 32'(count), DEPTH);
            end else begin
                exp_v = (exp_v << 8) | (32'h20 + k);
            end
            tick();
            mon_sample();
        end
        in_valid = 1'b0;
        chk("full_count_hold", 32'(count), DEPTH);
        asrs_full = 1'b0;
        repeat (12) begin tick(); mon_sample(); end
        chk("drain_nstrobe", 32'(nstrobe), DEPTH);
        chk("drain_order", offs, exp_v);
        chk("drain_count", 32'(count), 0);

        // NOP, reserved 101, ADDI
        mon_clear();
        push_one(mk(3'd7, 3'd1, 3'd1, 7'h11));
        push_one(mk(3'd5, 3'd1, 3'd1, 7'h22));
        push_one(mk(3'd2, 3'd5, 3'd6, 7'h33));
        repeat (6) begin tick(); mon_sample(); end
        chk("drop_illegal_pulses", 32'(n_ill), 1);
        chk("drop_issue_seq", seq, 32'h1);
        chk("drop_addi_offset", offs, 32'h33);
        chk("drop_exclusive", 32'(both_high), 0);

        // flush with a word offered and three queued
        mon_clear();
        asrs_full = 1'b1;
        push_one(mk(3'd0, 3'd0, 3'd0, 7'h30));
        push_one(mk(3'd0, 3'd0, 3'd0, 7'h31));
        push_one(mk(3'd0, 3'd0, 3'd0, 7'h32));
        chk("flush_pre_count", 32'(count), 3);
        in_instr = mk(3'd0, 3'd0, 3'd0, 7'h55);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        mon_sample();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_fields_hold", {16'd0, opcode, rd, rs, offset}, {16'd0, 3'd2, 3'd5, 3'd6, 7'h33});
        asrs_full = 1'b0;
        repeat (5) begin tick(); mon_sample(); end
        chk("flush_no_strobe", 32'(nstrobe), 0);
        chk("flush_count_after", 32'(count), 0);

        // asynchronous reset mid-stall
        mon_clear();
        asrs_full = 1'b1;
        push_one(mk(3'd0, 3'd3, 3'd3, 7'h44));
        push_one(mk(3'd3, 3'd3, 3'd3, 7'h45));
        #2;
        CLR = 1'b0;
        #1;
        chk("clr_count", 32'(count), 0);
        chk("clr_in_ready", 32'(in_ready), 1);
        chk("clr_strobes", {29'd0, issue_as, issue_ls, illegal}, 0);
        chk("clr_fields", {16'd0, opcode, rd, rs, offset}, 0);
        tick();
        CLR = 1'b1;
        asrs_full = 1'b0;
        repeat (4) begin tick(); mon_sample(); end
        chk("clr_queue_lost", 32'(nstrobe + n_ill), 0);

        // randomized run against the reference model
        CLR = 1'b0;
        tick();
        CLR = 1'b1;
        mq.delete();
        last_as = -100;
        last_ls = -100;
        edge_n  = 0;
        m_op = '0; m_rd = '0; m_rs = '0; m_off = '0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_instr  = 16'($urandom);
            asrs_full = ($urandom_range(0, 3) == 0);
            lsrs_full = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            m_as = 1'b0; m_ls = 1'b0; m_ill = 1'b0;
            if (flush) begin
                mq.delete();
                last_as = -100;
                last_ls = -100;
            end else begin
                sz = mq.size();
                if (sz > 0) begin
                    h = mq[0];
                    case (cls(h[15:13]))
                        0: if (!asrs_full && (edge_n - last_as) >= 2) begin
                            m_as = 1'b1;
                            last_as = edge_n;
                        end
                        1: if (!lsrs_full && (edge_n - last_ls) >= 2) begin
                            m_ls = 1'b1;
                            last_ls = edge_n;
                        end
                        3: m_ill = 1'b1;
                        default: ;
                    endcase
                    if (m_as || m_ls) begin
                        m_op  = h[15:13];
                        m_rd  = h[12:10];
                        m_rs  = h[9:7];
                        m_off = h[6:0];
                    end
                    if (m_as || m_ls || cls(h[15:13]) >= 2) void'(mq.pop_front());
                end
                if (in_valid && sz < DEPTH) mq.push_back(in_instr);
            end
            tick();
            edge_n++;
            exp_v = {9'd0, 3'(mq.size()), (mq.size() < DEPTH), m_as, m_ls, m_ill,
                     m_op, m_rd, m_rs, m_off};
            act_v = {9'd0, count, in_ready, issue_as, issue_ls, illegal,
                     opcode, rd, rs, offset};
            chk($sformatf("rand_cycle%0d", c), act_v, exp_v);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
